// File: rtl/tinyriscv_pkg.sv
// Shared bus types and RIB responder helpers for the tinyriscv memory slice.
package tinyriscv_pkg;

  typedef logic [31:0] MemBus;
  typedef logic [31:0] MemAddrBus;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } rib_resp_state_e;

  localparam int unsigned RIB_WAIT_W = 4;

  // True when base <= addr < base + 4*depth_words; 33-bit limit so a window ending at 4 GiB still works.
  function automatic logic rib_addr_hit(input MemAddrBus   addr,
                                        input MemAddrBus   base,
                                        input int unsigned depth_words);
    logic [32:0] limit;
    limit = {1'b0, base} + ({1'b0, depth_words} << 2);
    return (addr >= base) && ({1'b0, addr} < limit);
  endfunction

endpackage

// File: rtl/rib_resp_port_fsm.sv
// Per-port IDLE -> WAIT -> RESP sequencer; fire_o is the one-cycle response slot.
module rib_resp_port_fsm
  import tinyriscv_pkg::*;
#(
  parameter int unsigned N_WAIT = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic abort_i,
  output logic busy_o,
  output logic fire_o
);

  // WAIT lasts N_WAIT cycles, so the counter is loaded with N_WAIT-1 and RESP follows when it reads zero.
  localparam int unsigned WAIT_LOAD_I = (N_WAIT > 0) ? N_WAIT - 1 : 0;
  localparam logic [RIB_WAIT_W-1:0] WAIT_LOAD = WAIT_LOAD_I[RIB_WAIT_W-1:0];

  rib_resp_state_e state_q, state_d;
  logic [RIB_WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (N_WAIT == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - {{(RIB_WAIT_W-1){1'b0}}, 1'b1};
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign fire_o = (state_q == RESP);

endmodule

// File: rtl/rib_mem_responder.sv
// RIB slave for the tinyriscv IF and EX ports: word memory with a read-only IF port,
// a read/write EX port, per-port wait states and a sticky out-of-range flag.
module rib_mem_responder
  import tinyriscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter MemAddrBus   BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned IF_WAIT     = 0,
  parameter int unsigned EX_WAIT     = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  MemAddrBus pc_addr_i,
  output MemBus     pc_data_o,
  output logic      pc_ready_o,
  input  MemAddrBus ex_addr_i,
  input  MemBus     ex_data_i,
  input  logic      ex_we_i,
  input  logic      ex_req_i,
  output MemBus     ex_data_o,
  output logic      ex_ready_o,
  output logic      err_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] BASE_IDX = BASE_ADDR[AW+1:2];

  logic          pc_busy, pc_fire, pc_abort, pc_hit_now;
  logic          ex_busy, ex_fire, ex_abort, ex_accept, ex_hit_now;
  logic [29:0]   pc_word_q, pc_word_d;
  logic          pc_hit_q, pc_hit_d;
  logic [AW-1:0] ex_idx_q, ex_idx_d;
  logic          ex_hit_q, ex_hit_d;
  logic          ex_we_q, ex_we_d;
  MemBus         ex_wdata_q, ex_wdata_d;
  logic          err_q, err_d;
  logic [AW-1:0] pc_rd_idx, ex_rd_idx;
  logic          mem_we;
  MemBus         mem_q [DEPTH_WORDS];
  MemBus         pc_rdata_q, ex_rdata_q;

  assign pc_hit_now = rib_addr_hit(pc_addr_i, BASE_ADDR, DEPTH_WORDS);
  assign ex_hit_now = rib_addr_hit(ex_addr_i, BASE_ADDR, DEPTH_WORDS);
  assign pc_abort   = (pc_addr_i[31:2] != pc_word_q);
  assign ex_abort   = !ex_req_i;
  assign ex_accept  = ex_req_i && !ex_busy;

  rib_resp_port_fsm #(.N_WAIT(IF_WAIT)) u_pc_fsm (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (1'b1),
    .abort_i (pc_abort),
    .busy_o  (pc_busy),
    .fire_o  (pc_fire)
  );

  rib_resp_port_fsm #(.N_WAIT(EX_WAIT)) u_ex_fsm (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (ex_req_i),
    .abort_i (ex_abort),
    .busy_o  (ex_busy),
    .fire_o  (ex_fire)
  );

  always_comb begin
    pc_word_d  = pc_word_q;
    pc_hit_d   = pc_hit_q;
    ex_idx_d   = ex_idx_q;
    ex_hit_d   = ex_hit_q;
    ex_we_d    = ex_we_q;
    ex_wdata_d = ex_wdata_q;
    err_d      = err_q;

    if (!pc_busy) begin
      pc_word_d = pc_addr_i[31:2];
      pc_hit_d  = pc_hit_now;
      err_d     = err_d | !pc_hit_now;
    end
    if (ex_accept) begin
      ex_idx_d   = ex_addr_i[AW+1:2] - BASE_IDX;
      ex_hit_d   = ex_hit_now;
      ex_we_d    = ex_we_i;
      ex_wdata_d = ex_data_i;
      err_d      = err_d | !ex_hit_now;
    end

    // While idle the read follows the incoming address so a zero-wait port has data ready in RESP.
    pc_rd_idx = pc_busy ? (pc_word_q[AW-1:0] - BASE_IDX) : (pc_addr_i[AW+1:2] - BASE_IDX);
    ex_rd_idx = ex_busy ? ex_idx_q : (ex_addr_i[AW+1:2] - BASE_IDX);
    mem_we    = ex_fire && ex_we_q && ex_hit_q && rst_ni;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_word_q  <= '0;
      pc_hit_q   <= 1'b0;
      ex_idx_q   <= '0;
      ex_hit_q   <= 1'b0;
      ex_we_q    <= 1'b0;
      ex_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      pc_word_q  <= pc_word_d;
      pc_hit_q   <= pc_hit_d;
      ex_idx_q   <= ex_idx_d;
      ex_hit_q   <= ex_hit_d;
      ex_we_q    <= ex_we_d;
      ex_wdata_q <= ex_wdata_d;
      err_q      <= err_d;
    end
  end

  // 1R + 1RW array; the IF read samples old contents when the EX write hits the same word.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[ex_rd_idx] <= ex_wdata_q;
    end
    pc_rdata_q <= mem_q[pc_rd_idx];
    ex_rdata_q <= mem_q[ex_rd_idx];
  end

  assign pc_ready_o = pc_fire;
  assign pc_data_o  = (pc_fire && pc_hit_q) ? pc_rdata_q : '0;
  assign ex_ready_o = ex_fire;
  assign ex_data_o  = (ex_fire && ex_hit_q && !ex_we_q) ? ex_rdata_q : '0;
  assign err_o      = err_q;

endmodule

// File: tb/tb_rib_mem_responder.sv
// Bench for rib_mem_responder: directed table, hand-written corner sequences and a randomized model check.
module tb_rib_mem_responder;
  import tinyriscv_pkg::*;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned A_EXW = 1;
  localparam int unsigned B_IFW = 3;
  localparam int unsigned B_EXW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  MemAddrBus a_pc_addr, a_ex_addr, b_pc_addr, b_ex_addr;
  MemBus     a_pc_data, a_ex_wdata, a_ex_rdata, b_pc_data, b_ex_wdata, b_ex_rdata;
  logic      a_pc_ready, a_ex_we, a_ex_req, a_ex_ready, a_err;
  logic      b_pc_ready, b_ex_we, b_ex_req, b_ex_ready, b_err;

  rib_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .IF_WAIT(0), .EX_WAIT(A_EXW)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .pc_addr_i(a_pc_addr), .pc_data_o(a_pc_data), .pc_ready_o(a_pc_ready),
    .ex_addr_i(a_ex_addr), .ex_data_i(a_ex_wdata), .ex_we_i(a_ex_we), .ex_req_i(a_ex_req),
    .ex_data_o(a_ex_rdata), .ex_ready_o(a_ex_ready), .err_o(a_err)
  );

  rib_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .IF_WAIT(B_IFW), .EX_WAIT(B_EXW)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .pc_addr_i(b_pc_addr), .pc_data_o(b_pc_data), .pc_ready_o(b_pc_ready),
    .ex_addr_i(b_ex_addr), .ex_data_i(b_ex_wdata), .ex_we_i(b_ex_we), .ex_req_i(b_ex_req),
    .ex_data_o(b_ex_rdata), .ex_ready_o(b_ex_ready), .err_o(b_err)
  );

  int n_vec = 0;
  int n_bad = 0;
  MemBus ref_mem [DEPTH];
  logic  ref_err = 1'b0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t vt [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // One EX transaction; lat counts cycles from the request cycle to the ready cycle.
  task automatic ex_txn(input bit sel_b, input MemAddrBus addr, input bit we, input MemBus wdata,
                        output MemBus rdata, output int lat);
    @(posedge clk); #1;
    if (sel_b) begin
      b_ex_addr = addr; b_ex_we = we; b_ex_wdata = wdata; b_ex_req = 1'b1;
    end else begin
      a_ex_addr = addr; a_ex_we = we; a_ex_wdata = wdata; a_ex_req = 1'b1;
    end
    lat   = 0;
    rdata = 'x;
    forever begin
      @(negedge clk);
      if (sel_b ? b_ex_ready : a_ex_ready) begin
        rdata = sel_b ? b_ex_rdata : a_ex_rdata;
        break;
      end
      lat++;
      if (lat > 30) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (sel_b) begin
      b_ex_req = 1'b0; b_ex_we = 1'b0;
    end else begin
      a_ex_req = 1'b0; a_ex_we = 1'b0;
    end
  endtask

  task automatic wait_pc_ready(input bit sel_b, input string tag, output MemBus data);
    data = '0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (sel_b ? b_pc_ready : a_pc_ready) begin
        data = sel_b ? b_pc_data : a_pc_data;
        return;
      end
    end
    n_vec++;
    n_bad++;
    $display("FAIL %s: no pc_ready within 40 cycles, required a pulse", tag);
  endtask

  function automatic MemBus model_expect(input MemAddrBus addr, input bit we);
    if (addr < DEPTH * 4 && !we) return ref_mem[int'(addr >> 2)];
    return '0;
  endfunction

  function automatic void model_update(input MemAddrBus addr, input bit we, input MemBus wdata);
    if (addr < DEPTH * 4) begin
      if (we) ref_mem[int'(addr >> 2)] = wdata;
    end else begin
      ref_err = 1'b1;
    end
  endfunction

  task automatic ex_check(input MemAddrBus addr, input bit we, input MemBus wdata, input string tag);
    MemBus rd, exp_rd;
    int    lat;
    exp_rd = model_expect(addr, we);
    ex_txn(1'b0, addr, we, wdata, rd, lat);
    model_update(addr, we, wdata);
    @(negedge clk);
    $display("%s: we=%0b addr=%h wdata=%h rdata=%h lat=%0d err=%0b", tag, we, addr, wdata, rd, lat, a_err);
    chk({tag, " lat"}, 32'(lat), 32'(1 + A_EXW));
    chk({tag, " rdata"}, rd, exp_rd);
    chk({tag, " err"}, 32'(a_err), 32'(ref_err));
  endtask

  task automatic if_check_a(input int unsigned widx);
    MemBus d;
    @(posedge clk); #1;
    a_pc_addr = widx * 4 + $urandom_range(0, 3);
    wait_pc_ready(1'b0, "if rnd sync", d);
    wait_pc_ready(1'b0, "if rnd", d);
    $display("if fetch: addr=%h data=%h", a_pc_addr, d);
    chk("if rnd data", d, ref_mem[widx]);
  endtask

  task automatic check_idle_a(input string tag);
    chk({tag, " pc_ready"}, 32'(a_pc_ready), 32'd0);
    chk({tag, " pc_data"}, a_pc_data, 32'd0);
    chk({tag, " ex_ready"}, 32'(a_ex_ready), 32'd0);
    chk({tag, " ex_data"}, a_ex_rdata, 32'd0);
    chk({tag, " err"}, 32'(a_err), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    MemBus rd, d, old_v, new_v;
    int    lat;

    rst_n = 1'b0;
    a_pc_addr = '0; a_ex_addr = '0; a_ex_wdata = '0; a_ex_we = 1'b0; a_ex_req = 1'b0;
    b_pc_addr = '0; b_ex_addr = '0; b_ex_wdata = '0; b_ex_we = 1'b0; b_ex_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vt[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h0000_0000, 32'h0000_0011, 32'h0000_0000, 1'b0};
    vt[3]  = '{1'b1, 32'h0000_0004, 32'h0000_0022, 32'h0000_0000, 1'b0};
    vt[4]  = '{1'b1, 32'h0000_0008, 32'h0000_0033, 32'h0000_0000, 1'b0};
    vt[5]  = '{1'b1, 32'h0000_0014, 32'h0000_5555, 32'h0000_0000, 1'b0};
    vt[6]  = '{1'b1, 32'h0000_001C, 32'h0000_7777, 32'h0000_0000, 1'b0};
    vt[7]  = '{1'b1, 32'h0000_0013, 32'h1234_5678, 32'h0000_0000, 1'b0};
    vt[8]  = '{1'b0, 32'h0000_0011, 32'h0000_0000, 32'h1234_5678, 1'b0};
    vt[9]  = '{1'b1, 32'h0000_00FC, 32'hA5A5_0001, 32'h0000_0000, 1'b0};
    vt[10] = '{1'b0, 32'h0000_00FE, 32'h0000_0000, 32'hA5A5_0001, 1'b0};
    vt[11] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vt[12] = '{1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vt[13] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0011, 1'b1};
    vt[14] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_a("reset");
    chk("reset b err", 32'(b_err), 32'd0);
    chk("reset b pc_ready", 32'(b_pc_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed EX table on port A
    for (int i = 0; i < 15; i++) begin
      ex_txn(1'b0, vt[i].addr, vt[i].we, vt[i].wdata, rd, lat);
      model_update(vt[i].addr, vt[i].we, vt[i].wdata);
      @(negedge clk);
      $display("vec %0d: we=%0b addr=%h wdata=%h rdata=%h lat=%0d err=%0b",
               i, vt[i].we, vt[i].addr, vt[i].wdata, rd, lat, a_err);
      chk($sformatf("vec%0d lat", i), 32'(lat), 32'(1 + A_EXW));
      chk($sformatf("vec%0d rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d err", i), 32'(a_err), 32'(vt[i].exp_err));
    end

    // IF stepping 0,4,8 with zero wait: a pulse every second cycle
    wait_pc_ready(1'b0, "if step sync", d);
    chk("if step word0", d, 32'h0000_0011);
    for (int k = 1; k < 3; k++) begin
      @(posedge clk); #1;
      a_pc_addr = 32'(k * 4);
      @(negedge clk);
      chk($sformatf("if step%0d gap", k), 32'(a_pc_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      $display("if step: addr=%h ready=%0b data=%h", a_pc_addr, a_pc_ready, a_pc_data);
      chk($sformatf("if step%0d ready", k), 32'(a_pc_ready), 32'd1);
      chk($sformatf("if step%0d data", k), a_pc_data, (k == 1) ? 32'h0000_0022 : 32'h0000_0033);
    end

    // EX write of word 5 lands in the same cycle as the IF response for word 5
    @(posedge clk); #1;
    a_pc_addr = 32'h14;
    @(posedge clk);
    @(negedge clk);
    chk("coll pre ready", 32'(a_pc_ready), 32'd1);
    chk("coll pre data", a_pc_data, 32'h0000_5555);
    new_v = 32'hC0FF_EE05;
    @(posedge clk);
    @(posedge clk); #1;
    a_ex_addr = 32'h14; a_ex_we = 1'b1; a_ex_wdata = new_v; a_ex_req = 1'b1;
    @(negedge clk);
    chk("coll ex c0", 32'(a_ex_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("coll ex c1", 32'(a_ex_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    $display("collision: ex_ready=%0b pc_ready=%0b pc_data=%h", a_ex_ready, a_pc_ready, a_pc_data);
    chk("coll ex ready", 32'(a_ex_ready), 32'd1);
    chk("coll pc ready", 32'(a_pc_ready), 32'd1);
    chk("coll pc old data", a_pc_data, 32'h0000_5555);
    @(posedge clk); #1;
    a_ex_req = 1'b0; a_ex_we = 1'b0;
    ref_mem[5] = new_v;
    wait_pc_ready(1'b0, "coll next", d);
    chk("coll pc new data", d, new_v);

    // Randomized phase against the model: fill every word, then mixed traffic
    for (int i = 0; i < DEPTH; i++) ex_check(32'(i * 4), 1'b1, $urandom, "fill");
    for (int i = 0; i < 40; i++) begin
      ex_check($urandom_range(0, DEPTH * 4 + 31), 1'($urandom_range(0, 1)), $urandom, "rnd");
      if (i % 2 == 0) if_check_a($urandom_range(0, DEPTH - 1));
    end

    // EX request withdrawn during WAIT: no pulse, no write
    old_v = ref_mem[9];
    @(posedge clk); #1;
    a_ex_addr = 32'h24; a_ex_we = 1'b1; a_ex_wdata = ~old_v; a_ex_req = 1'b1;
    @(negedge clk);
    chk("ex abort c0", 32'(a_ex_ready), 32'd0);
    @(posedge clk); #1;
    a_ex_req = 1'b0; a_ex_we = 1'b0;
    @(negedge clk);
    chk("ex abort c1", 32'(a_ex_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("ex abort c2", 32'(a_ex_ready), 32'd0);
    ex_check(32'h24, 1'b0, 32'h0, "ex abort read");

    // Reset while an EX write sits in WAIT
    old_v = ref_mem[7];
    @(posedge clk); #1;
    a_ex_addr = 32'h1C; a_ex_we = 1'b1; a_ex_wdata = ~old_v; a_ex_req = 1'b1;
    @(negedge clk);
    chk("rst c0 ready", 32'(a_ex_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst c1 ready", 32'(a_ex_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_idle_a("rst mid");
    @(posedge clk); #1;
    a_ex_req = 1'b0; a_ex_we = 1'b0; rst_n = 1'b1;
    ref_err = 1'b0;
    ex_check(32'h1C, 1'b0, 32'h0, "rst read");

    // Port B: IF_WAIT=3, address change during WAIT aborts the fetch
    ex_txn(1'b1, 32'h00, 1'b1, 32'hB0B0_0000, rd, lat);
    chk("b fill0 lat", 32'(lat), 32'(1 + B_EXW));
    ex_txn(1'b1, 32'h20, 1'b1, 32'hB0B0_0008, rd, lat);
    chk("b fill8 lat", 32'(lat), 32'(1 + B_EXW));
    ex_txn(1'b1, 32'h20, 1'b0, 32'h0, rd, lat);
    chk("b read8 lat", 32'(lat), 32'(1 + B_EXW));
    chk("b read8 data", rd, 32'hB0B0_0008);
    wait_pc_ready(1'b1, "b if sync", d);
    chk("b if word0", d, 32'hB0B0_0000);
    @(posedge clk);
    @(posedge clk); #1;
    b_pc_addr = 32'h20;
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      $display("b if abort: cycle +%0d ready=%0b data=%h", k, b_pc_ready, b_pc_data);
      chk($sformatf("b if abort c%0d ready", k), 32'(b_pc_ready), (k == 7) ? 32'd1 : 32'd0);
      if (k == 7) chk("b if restart data", b_pc_data, 32'hB0B0_0008);
      if (k < 7) @(posedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
